alu_muldiv: RTL
===============

# alu_muldiv

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the ALU operand front stage. Consumes the prepared operand pair (`op1`, `op2`) and the R-type `func` field. Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle. Services MFHI/MFLO/MTHI/MTLO, and raises `stall` to the pipeline when a new HI/LO operation arrives while a previous one is still running.

## Interface
- `WIDTH`, 32: operand and HI/LO width; `ITER` = `WIDTH` iterations.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  R-type instruction valid this cycle; `func` and operands qualified
- `func`  in  6  R-type function field
- `op1`  in  WIDTH  rs operand (multiplicand / dividend / MT* source)
- `op2`  in  WIDTH  rt operand (multiplier / divisor)
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register
- `busy`  out  1  iterative operation in progress
- `done`  out  1  one-cycle pulse: HI/LO just updated by mul/div
- `stall`  out  1  combinational: `start` & HI/LO-class `func` & `busy`

## Operation
- Func codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. All other `func` values are ignored.
- MFHI/MFLO: no state change. Readers take `hi`/`lo` directly, but must honour `stall`.
- MTHI/MTLO, accepted when idle: `op1` is written to `hi`/`lo` at the next edge.
- States:
  - IDLE: accepts `start` with mul/div `func`, then goes to PREP.
  - PREP, 1 cycle: latch |op1|, |op2| (signed ops) or raw values (unsigned ops); latch the signed flag, sign of result, and sign of dividend.
  - RUN, 32 cycles: iteration counter runs 31 down to 0.
  - FIX, 1 cycle: sign correction, write HI/LO, pulse `done`.
  - Return to IDLE.
- Multiply: shift-add into a 64-bit accumulator. Final {HI,LO} = product, negated if the signed operand signs differ.
- Divide: restoring division. LO = quotient, negated if the signed operand signs differ. HI = remainder, carrying the sign of the dividend.
- Divide by zero, signed or unsigned: HI = `op1` as sampled, LO = 0xFFFFFFFF. No sign fix applies, and the full latency is still taken.
- Signed 0x80000000 / -1: LO = 0x80000000, HI = 0. No trap.
- Any HI/LO-class `func` with `start` while `busy`: `stall`=1, the request is ignored, and upstream holds and re-presents it.
- Reset, including mid-operation: state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0. Any in-flight result is discarded.

## Timing
- Mul/div accepted at edge E0. `busy`=1 from E0 through E0+34. HI/LO are written at edge E0+34. `done`=1 during the cycle following E0+34, and `busy`=0 in that same cycle. Total 34-cycle latency.
- A back-to-back mul/div may be accepted in the `done` cycle.
- MT* latency: 1 edge. An MF* issued in the cycle after MT* sees the new value.
- `stall` is purely combinational from `start`/`func`/`busy`; there is no registered path.
- `busy` and `done` are registered. `hi` and `lo` are register outputs.

## Structure
- Shared package `mips_pkg`: func code constants (FUNC_MFHI … FUNC_DIVU), the `muldiv_state_t` enum {IDLE, PREP, RUN, FIX}, and `WIDTH`.
- One sub-module, `muldiv_iter`: the 64-bit shift datapath and counter, controlled by `load`, `is_div`, `step`, with `remainder`, `quotient`, and `product` outputs.
- Top level `alu_muldiv` owns the FSM, sign handling, and HI/LO registers.

## Test plan
- MULT with `op1`=17, `op2`=0xFFFF0001 (-65535): after 34 edges `hi`=0xFFFFFFFF, `lo`=0xFFEF0011, `done` pulses once.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF: `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV with -7 / 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU with 5 / 0: `hi`=5, `lo`=0xFFFFFFFF.
- MTHI 0x12345678, then MFHI next cycle: `hi`=0x12345678 after 1 edge. MTLO issued while `busy`: `stall`=1 and `lo` is unchanged.
- MULT started, then `rst` at cycle 10: the next cycle shows `busy`=0, `hi`=`lo`=0, and `done` is never pulsed.
- Back-to-back MULT issued in the `done` cycle: accepted with `stall`=0, and the second result appears 34 edges later.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared func codes, FSM state type and width for the mul/div unit
package mips_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} muldiv_state_t;

  function automatic logic is_hilo_func(input logic [5:0] f);
    return f inside {FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO,
                     FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
  endfunction

  function automatic logic is_muldiv_func(input logic [5:0] f);
    return f inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/result bundle between the ALU front stage and the mul/div unit
interface alu_muldiv_if;
  import mips_pkg::*;

  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (output start, func, op1, op2, input hi, lo, busy, done, stall);
  modport slave  (input start, func, op1, op2, output hi, lo, busy, done, stall);
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath
module muldiv_iter
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               is_div,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [WIDTH-1:0]   remainder,
  output logic [WIDTH-1:0]   quotient,
  output logic [2*WIDTH-1:0] product
);
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum, shifted, trial;

  // Multiply: add into the upper half then shift right. Divide: shift left, trial-subtract.
  always_comb begin
    acc_d   = acc_q;
    sum     = '0;
    shifted = '0;
    trial   = '0;
    if (is_div) begin
      shifted = acc_q[2*WIDTH-1:WIDTH-1];
      trial   = shifted - {1'b0, mcand_q};
      if (trial[WIDTH]) acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else              acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      acc_q   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      mcand_q <= is_div ? b : a;
      cnt_q   <= CNT_W'(WIDTH - 1);
    end else if (step) begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  assign last      = (cnt_q == '0);
  assign remainder = acc_q[2*WIDTH-1:WIDTH];
  assign quotient  = acc_q[WIDTH-1:0];
  assign product   = acc_q;
endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - mul/div sequencer with sign handling and architectural HI/LO
module alu_muldiv
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  alu_muldiv_if.slave bus
);
  muldiv_state_t      state_q;
  logic [WIDTH-1:0]   op1_q, op2_q, hi_q, lo_q, hi_d, lo_d, a_abs, b_abs;
  logic               is_div_q, signed_q, neg_res_q, neg_dvd_q, busy_q, done_q;
  logic               last;
  logic [WIDTH-1:0]   remainder, quotient;
  logic [2*WIDTH-1:0] product, product_fix;

  assign bus.stall = bus.start & is_hilo_func(bus.func) & busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  always_comb begin
    a_abs = (signed_q && op1_q[WIDTH-1]) ? -op1_q : op1_q;
    b_abs = (signed_q && op2_q[WIDTH-1]) ? -op2_q : op2_q;
  end

  // Divide by zero bypasses sign fix-up: HI gets the raw dividend, LO all ones.
  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    product_fix = neg_res_q ? -product : product;
    if (is_div_q) begin
      if (op2_q == '0) begin
        hi_d = op1_q;
        lo_d = '1;
      end else begin
        lo_d = neg_res_q ? -quotient : quotient;
        hi_d = neg_dvd_q ? -remainder : remainder;
      end
    end else begin
      {hi_d, lo_d} = product_fix;
    end
  end

  muldiv_iter u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == PREP),
    .is_div    (is_div_q),
    .step      (state_q == RUN),
    .a         (a_abs),
    .b         (b_abs),
    .last      (last),
    .remainder (remainder),
    .quotient  (quotient),
    .product   (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      signed_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (is_muldiv_func(bus.func)) begin
              op1_q    <= bus.op1;
              op2_q    <= bus.op2;
              is_div_q <= bus.func[1];
              signed_q <= ~bus.func[0];
              busy_q   <= 1'b1;
              state_q  <= PREP;
            end else if (bus.func == FUNC_MTHI) begin
              hi_q <= bus.op1;
            end else if (bus.func == FUNC_MTLO) begin
              lo_q <= bus.op1;
            end
          end
        end
        PREP: begin
          neg_res_q <= signed_q & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
          neg_dvd_q <= signed_q & op1_q[WIDTH-1];
          state_q   <= RUN;
        end
        RUN: begin
          if (last) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
